// File: rtl/sender_queue.sv
// Transmit queue: buffers {msg,dest} and delivers each entry as SETUP -> STROBE -> RECOVER on left/right/self.
// Optional feature macro SENDER_QUEUE_BROADCAST_EN: dest=11 delivers on left and right together.
module sender_queue #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 4,
   parameter int STROBE_LEN = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           msg_in,
   input  logic [1:0]                 dest,
   input  logic                       wr_en,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       dest_err,
   output logic                       busy,
   output logic [WIDTH-1:0]           out_sig_left,
   output logic [WIDTH-1:0]           out_sig_right,
   output logic [WIDTH-1:0]           out_sig_self,
   output logic                       check_l,
   output logic                       check_r,
   output logic                       check_s
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

   logic [WIDTH-1:0] r_mem_dat [DEPTH];
   logic [1:0]       r_mem_dst [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             r_full, r_empty, r_overflow, r_dest_err;
   state_t           r_state;
   logic [SW-1:0]    r_strb_cnt;
   logic [WIDTH-1:0] r_tx_data;
   logic [2:0]       r_tx_mask;
   logic             r_busy;
   logic [2:0]       r_chk;
   logic [WIDTH-1:0] r_out_l, r_out_r, r_out_s;

   logic             w_dest_ok, w_full, w_pop, w_push;
   logic [CW-1:0]    w_count_nxt;

   // Target mask: bit0 left, bit1 right, bit2 self.
   function automatic logic [2:0] f_mask(input logic [1:0] d);
      case (d)
         2'b00:   f_mask = 3'b001;
         2'b10:   f_mask = 3'b010;
         2'b01:   f_mask = 3'b100;
`ifdef SENDER_QUEUE_BROADCAST_EN
         default: f_mask = 3'b011;
`else
         default: f_mask = 3'b000;
`endif
      endcase
   endfunction

`ifdef SENDER_QUEUE_BROADCAST_EN
   assign w_dest_ok = 1'b1;
`else
   assign w_dest_ok = (dest != 2'b11);
`endif

   assign w_full      = (r_count == CW'(DEPTH));
   assign w_pop       = (r_state == IDLE) && (r_count != '0);
   assign w_push      = wr_en && w_dest_ok && (!w_full || w_pop);
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_dat[i] <= '0;
            r_mem_dst[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
         r_dest_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem_dat[r_wr_ptr] <= msg_in;
            r_mem_dst[r_wr_ptr] <= dest;
            r_wr_ptr            <= r_wr_ptr + AW'(1);
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count    <= w_count_nxt;
         r_full     <= (w_count_nxt == CW'(DEPTH));
         r_empty    <= (w_count_nxt == '0);
         r_overflow <= wr_en && w_dest_ok && w_full && !w_pop;
         r_dest_err <= wr_en && !w_dest_ok;
      end
   end

   // Outputs are registered from the current state, so they trail the state by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_strb_cnt <= '0;
         r_tx_data  <= '0;
         r_tx_mask  <= '0;
         r_busy     <= 1'b0;
         r_chk      <= '0;
         r_out_l    <= '0;
         r_out_r    <= '0;
         r_out_s    <= '0;
      end else begin
         r_busy <= (r_state != IDLE);
         r_chk  <= (r_state == STROBE) ? r_tx_mask : 3'b000;
         if (r_state == SETUP) begin
            if (r_tx_mask[0]) r_out_l <= r_tx_data;
            if (r_tx_mask[1]) r_out_r <= r_tx_data;
            if (r_tx_mask[2]) r_out_s <= r_tx_data;
         end
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_tx_data <= r_mem_dat[r_rd_ptr];
                  r_tx_mask <= f_mask(r_mem_dst[r_rd_ptr]);
                  r_state   <= SETUP;
               end
            end
            SETUP: begin
               r_strb_cnt <= '0;
               r_state    <= STROBE;
            end
            STROBE: begin
               if (r_strb_cnt == SW'(STROBE_LEN - 1))
                  r_state <= RECOVER;
               else
                  r_strb_cnt <= r_strb_cnt + SW'(1);
            end
            RECOVER: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign full          = r_full;
   assign empty         = r_empty;
   assign count         = r_count;
   assign overflow      = r_overflow;
   assign dest_err      = r_dest_err;
   assign busy          = r_busy;
   assign out_sig_left  = r_out_l;
   assign out_sig_right = r_out_r;
   assign out_sig_self  = r_out_s;
   assign check_l       = r_chk[0];
   assign check_r       = r_chk[1];
   assign check_s       = r_chk[2];
endmodule

// File: tb/tb_sender_queue.sv
// Randomized and directed bench for sender_queue against a queue-and-timeline reference model.
module tb_sender_queue;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int SL    = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [WIDTH-1:0]  msg_in;
   logic [1:0]        dest;
   logic              wr_en;
   logic              full, empty, overflow, dest_err, busy;
   logic [2:0]        count;
   logic [WIDTH-1:0]  out_sig_left, out_sig_right, out_sig_self;
   logic              check_l, check_r, check_s;

   int checks = 0;
   int errors = 0;

   sender_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STROBE_LEN(SL)) dut (
      .clk(clk), .reset(reset), .msg_in(msg_in), .dest(dest), .wr_en(wr_en),
      .full(full), .empty(empty), .count(count), .overflow(overflow), .dest_err(dest_err),
      .busy(busy), .out_sig_left(out_sig_left), .out_sig_right(out_sig_right),
      .out_sig_self(out_sig_self), .check_l(check_l), .check_r(check_r), .check_s(check_s)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: pending queue plus a delivery timeline. A message popped at edge p
   // drives its output(s) after p+1, strobes after p+2..p+1+SL, and the sender reads busy
   // after p+1..p+2+SL; the next pop may happen no earlier than p+3+SL.
   logic [WIDTH-1:0] pend_m[$];
   logic [1:0]       pend_d[$];
   int               cyc, next_pop, last_pop;
   logic [WIDTH-1:0] last_dat;
   logic [2:0]       last_mask;
   logic [WIDTH-1:0] exp_out[3];
   logic [2:0]       exp_chk;
   logic             exp_busy, exp_ovf, exp_derr;
   int               exp_cnt;

   function automatic logic [2:0] side_mask(input logic [1:0] d);
      case (d)
         2'b00:   return 3'b001;
         2'b10:   return 3'b010;
         2'b01:   return 3'b100;
`ifdef SENDER_QUEUE_BROADCAST_EN
         default: return 3'b011;
`else
         default: return 3'b000;
`endif
      endcase
   endfunction

   function automatic bit dest_ok(input logic [1:0] d);
`ifdef SENDER_QUEUE_BROADCAST_EN
      return 1'b1;
`else
      return d != 2'b11;
`endif
   endfunction

   task automatic model_reset();
      pend_m.delete();
      pend_d.delete();
      cyc = 0; next_pop = 0; last_pop = -100;
      last_dat = '0; last_mask = '0;
      for (int i = 0; i < 3; i++) exp_out[i] = '0;
      exp_chk = '0; exp_busy = 0; exp_ovf = 0; exp_derr = 0; exp_cnt = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_en = 1'b0; msg_in = '0; dest = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Drive one cycle from a negedge, advance the model over the edge, return at next negedge.
   task automatic run_cycle(input logic wr, input logic [WIDTH-1:0] m, input logic [1:0] d);
      wr_en = wr; msg_in = m; dest = d;
      @(posedge clk);
      if (pend_m.size() > 0 && cyc >= next_pop) begin
         last_pop  = cyc;
         last_dat  = pend_m.pop_front();
         last_mask = side_mask(pend_d.pop_front());
         next_pop  = cyc + 3 + SL;
      end
      exp_ovf = 0; exp_derr = 0;
      if (wr) begin
         if (!dest_ok(d)) exp_derr = 1;
         else if (pend_m.size() < DEPTH) begin
            pend_m.push_back(m);
            pend_d.push_back(d);
         end else exp_ovf = 1;
      end
      exp_cnt = pend_m.size();
      if (cyc == last_pop + 1)
         for (int s = 0; s < 3; s++) if (last_mask[s]) exp_out[s] = last_dat;
      exp_chk  = (cyc >= last_pop + 2 && cyc <= last_pop + 1 + SL) ? last_mask : 3'b000;
      exp_busy = (cyc >= last_pop + 1 && cyc <= last_pop + SL + 2);
      cyc++;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      run_cycle(1, 32'h1111_2222, 2'b00);
      run_cycle(1, 32'h3333_4444, 2'b10);
      repeat (2) run_cycle(0, '0, 2'b00);
      reset = 1'b1;
      #1;
      checks++;
      if ({count, empty, full, busy, overflow, dest_err} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_status got cnt=%0d e=%b f=%b busy=%b ovf=%b derr=%b want 0 1 0 0 0 0",
                  count, empty, full, busy, overflow, dest_err);
      end
      checks++;
      if ({check_s, check_r, check_l} !== 3'b000) begin
         errors++;
         $display("FAIL reset_checks got %b want 000", {check_s, check_r, check_l});
      end
      checks++;
      if ({out_sig_left, out_sig_right, out_sig_self} !== '0) begin
         errors++;
         $display("FAIL reset_outs got %h %h %h want 0", out_sig_left, out_sig_right, out_sig_self);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_single();
      do_reset();
      run_cycle(1, 32'hDEAD_BEEF, 2'b00);                 // edge 0
      run_cycle(0, '0, 2'b00);                            // edge 1
      run_cycle(0, '0, 2'b00);                            // edge 2
      checks++;
      if (out_sig_left !== 32'hDEAD_BEEF || check_l !== 1'b0) begin
         errors++;
         $display("FAIL single_setup got left=%h chk=%b want DEADBEEF 0", out_sig_left, check_l);
      end
      run_cycle(0, '0, 2'b00);                            // edge 3
      checks++;
      if ({check_s, check_r, check_l} !== 3'b001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_strobe got chk=%b busy=%b want 001 1", {check_s, check_r, check_l}, busy);
      end
      run_cycle(0, '0, 2'b00);                            // edge 4
      checks++;
      if (check_l !== 1'b0 || busy !== 1'b1 || out_sig_left !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_recover got chk=%b busy=%b left=%h want 0 1 DEADBEEF", check_l, busy, out_sig_left);
      end
      run_cycle(0, '0, 2'b00);                            // edge 5
      checks++;
      if (busy !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL single_done got busy=%b empty=%b want 0 1", busy, empty);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] want_dat[4];
      logic [2:0]       want_side[4];
      logic [WIDTH-1:0] got_dat[$];
      logic [2:0]       got_side[$];
      int               got_edge[$];
      logic [2:0]       prev, chk;
      int               multi;
      want_dat  = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
      want_side = '{3'b001, 3'b010, 3'b100, 3'b001};
      do_reset();
      prev = '0; multi = 0;
      for (int i = 0; i < 34; i++) begin
         case (i)
            0: run_cycle(1, want_dat[0], 2'b00);
            1: run_cycle(1, want_dat[1], 2'b10);
            2: run_cycle(1, want_dat[2], 2'b01);
            3: run_cycle(1, want_dat[3], 2'b00);
            default: run_cycle(0, '0, 2'b00);
         endcase
         chk = {check_s, check_r, check_l};
         if ($countones(chk) > 1) multi++;
         if (chk != 3'b000 && prev == 3'b000) begin
            got_side.push_back(chk);
            got_edge.push_back(cyc - 1);
            got_dat.push_back(chk[0] ? out_sig_left : chk[1] ? out_sig_right : out_sig_self);
         end
         prev = chk;
      end
      checks++;
      if (got_dat.size() != 4 || multi != 0) begin
         errors++;
         $display("FAIL b2b_count got deliveries=%0d multi=%0d want 4 0", got_dat.size(), multi);
      end
      for (int i = 0; i < 4 && i < got_dat.size(); i++) begin
         checks++;
         if (got_dat[i] !== want_dat[i] || got_side[i] !== want_side[i] || got_edge[i] != 3 + 4 * i) begin
            errors++;
            $display("FAIL b2b_msg%0d got %h side=%b edge=%0d want %h side=%b edge=%0d", i,
                     got_dat[i], got_side[i], got_edge[i], want_dat[i], want_side[i], 3 + 4 * i);
         end
      end
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL b2b_empty got %b want 1", empty);
      end
   endtask

   task automatic test_overflow();
      int rises;
      logic prev_any;
      do_reset();
      rises = 0; prev_any = 0;
      for (int i = 0; i < 40; i++) begin
         if (i < 7) run_cycle(1, 32'h0F00_0000 + i, 2'b01);
         else run_cycle(0, '0, 2'b00);
         if (check_s && !prev_any) rises++;
         prev_any = check_s;
         if (i == 4) begin
            checks++;
            if (count !== 3'd4 || full !== 1'b1) begin
               errors++;
               $display("FAIL ovf_full got cnt=%0d full=%b want 4 1", count, full);
            end
         end
         if (i == 5) begin
            checks++;
            if (count !== 3'd4 || overflow !== 1'b0) begin
               errors++;
               $display("FAIL ovf_wr_pop got cnt=%0d ovf=%b want 4 0", count, overflow);
            end
         end
         if (i == 6 || i == 7) begin
            checks++;
            if (overflow !== (i == 6) || count !== 3'd4) begin
               errors++;
               $display("FAIL ovf_pulse%0d got ovf=%b cnt=%0d want %b 4", i, overflow, count, i == 6);
            end
         end
      end
      checks++;
      if (rises != 6 || empty !== 1'b1) begin
         errors++;
         $display("FAIL ovf_delivered got %0d empty=%b want 6 1", rises, empty);
      end
   endtask

   task automatic test_dest11();
      int n_l, n_r, n_s, n_both, n_bad;
      do_reset();
      n_l = 0; n_r = 0; n_s = 0; n_both = 0; n_bad = 0;
      run_cycle(1, 32'hCAFE_F00D, 2'b11);
`ifdef SENDER_QUEUE_BROADCAST_EN
      checks++;
      if (dest_err !== 1'b0 || count !== 3'd1) begin
         errors++;
         $display("FAIL bcast_accept got derr=%b cnt=%0d want 0 1", dest_err, count);
      end
`else
      checks++;
      if (dest_err !== 1'b1 || count !== 3'd0) begin
         errors++;
         $display("FAIL derr_pulse got derr=%b cnt=%0d want 1 0", dest_err, count);
      end
`endif
      for (int i = 0; i < 10; i++) begin
         run_cycle(0, '0, 2'b00);
         if (check_l) n_l++;
         if (check_r) n_r++;
         if (check_s) n_s++;
         if (check_l && check_r) begin
            n_both++;
            if (out_sig_left !== 32'hCAFE_F00D || out_sig_right !== 32'hCAFE_F00D) n_bad++;
         end
      end
`ifdef SENDER_QUEUE_BROADCAST_EN
      checks++;
      if (n_l != SL || n_r != SL || n_both != SL || n_s != 0 || n_bad != 0) begin
         errors++;
         $display("FAIL bcast_strobe got l=%0d r=%0d both=%0d s=%0d bad=%0d want %0d %0d %0d 0 0",
                  n_l, n_r, n_both, n_s, n_bad, SL, SL, SL);
      end
`else
      checks++;
      if (n_l + n_r + n_s != 0 || dest_err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL derr_nothing_sent got strobes=%0d derr=%b busy=%b want 0 0 0",
                  n_l + n_r + n_s, dest_err, busy);
      end
`endif
   endtask

   task automatic test_reset_mid_strobe();
      int waited;
      do_reset();
      run_cycle(1, 32'h1234_5678, 2'b10);
      run_cycle(1, 32'h8765_4321, 2'b00);
      waited = 0;
      while (check_r !== 1'b1 && waited < 12) begin
         run_cycle(0, '0, 2'b00);
         waited++;
      end
      checks++;
      if (check_r !== 1'b1) begin
         errors++;
         $display("FAIL midrst_reach got check_r=%b want 1 within 12 cycles", check_r);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (check_r !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async got check_r=%b busy=%b want 0 0", check_r, busy);
      end
      @(negedge clk);
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL midrst_count got cnt=%0d empty=%b want 0 1", count, empty);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      logic [107:0] act, expv;
      logic         w;
      logic [1:0]   d;
      int           bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         w = ($urandom_range(0, 99) < 45);
         d = 2'($urandom_range(0, 3));
         run_cycle(w, $urandom, d);
         act  = {count, full, empty, overflow, dest_err, busy, check_s, check_r, check_l,
                 out_sig_self, out_sig_right, out_sig_left};
         expv = {3'(exp_cnt), exp_cnt == DEPTH, exp_cnt == 0, exp_ovf, exp_derr, exp_busy, exp_chk,
                 exp_out[2], exp_out[1], exp_out[0]};
         checks++;
         if (act !== expv) begin
            errors++;
            bad++;
            if (bad <= 5)
               $display("FAIL random_cycle%0d got %h want %h", i, act, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_dest11();
      test_reset_mid_strobe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
